// File: rtl/mult_div_unit_if.sv
// Bus between the control unit and the signed multiply/divide unit.
// Holds the start strobes, operands, HI/LO results and status flags.
interface mult_div_unit_if #(parameter int WIDTH = 32);
  // Start protocol: multOP/divOP are sampled only when busy is low.
  // A request made while busy is dropped, not queued.
  // done pulses for one cycle once Hi/Lo hold the new result.
  logic             multOP;
  logic             divOP;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;
  logic             busy;
  logic             done;
  logic             divByZero;
  logic [1:0]       dbg_state;

  modport master (
    output multOP, divOP, A, B,
    input  Hi, Lo, busy, done, divByZero, dbg_state
  );

  modport slave (
    input  multOP, divOP, A, B,
    output Hi, Lo, busy, done, divByZero, dbg_state
  );
endinterface

// File: rtl/mult_div_unit.sv
// Sequential signed multiply (radix-2 Booth) and restoring divide for the MIPS HI/LO path.
// Optional MULTDIV_FAST_ZERO_EN: a multiply by zero skips the iterations.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input logic           clk,
    input logic           reset,
    mult_div_unit_if.slave bus
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, MULT = 2'd1, DIV = 2'd2, FINISH = 2'd3} state_t;

    state_t             state, next_state;
    logic   [CW-1:0]    cnt;
    logic   [2*WIDTH:0] acc;
    logic   [WIDTH-1:0] mcand;
    logic   [WIDTH-1:0] rem;
    logic   [WIDTH-1:0] quo;
    logic   [WIDTH-1:0] dvsr;
    logic               neg_q;
    logic               neg_r;
    logic   [WIDTH-1:0] hi_q;
    logic   [WIDTH-1:0] lo_q;
    logic               dbz_q;
    logic               start_mult;
    logic               start_div;
    logic               dbz_req;
    logic               last_step;
    logic   [WIDTH:0]   booth_sum;
    logic   [2*WIDTH:0] booth_next;
    logic   [WIDTH:0]   rem_shift;
    logic   [WIDTH:0]   trial;
    logic   [WIDTH-1:0] rem_next;
    logic               q_bit;
    logic   [WIDTH-1:0] a_mag;
    logic   [WIDTH-1:0] b_mag;

    assign last_step = (cnt == CW'(WIDTH));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        start_mult = 1'b0;
        start_div  = 1'b0;
        dbz_req    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.multOP) begin
                    next_state = MULT;
                    start_mult = 1'b1;
                end else if (bus.divOP) begin
                    if (bus.B == '0) begin
                        dbz_req = 1'b1;
                    end else begin
                        next_state = DIV;
                        start_div  = 1'b1;
                    end
                end
            end
            MULT, DIV: if (last_step) next_state = FINISH;
            FINISH:    next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    // Booth step: the add is done one bit wider so -2^(WIDTH-1) multiplicands cannot overflow.
    always_comb begin
        booth_sum = {acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]};
        case (acc[1:0])
            2'b01:   booth_sum = booth_sum + {mcand[WIDTH-1], mcand};
            2'b10:   booth_sum = booth_sum - {mcand[WIDTH-1], mcand};
            default: booth_sum = booth_sum;
        endcase
        booth_next = {booth_sum, acc[WIDTH:1]};
    end

    always_comb begin
        rem_shift = {rem, quo[WIDTH-1]};
        trial     = rem_shift - {1'b0, dvsr};
        q_bit     = ~trial[WIDTH];
        rem_next  = q_bit ? trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];
        a_mag     = bus.A[WIDTH-1] ? -bus.A : bus.A;
        b_mag     = bus.B[WIDTH-1] ? -bus.B : bus.B;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt   <= '0;
            acc   <= '0;
            mcand <= '0;
            rem   <= '0;
            quo   <= '0;
            dvsr  <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            hi_q  <= '0;
            lo_q  <= '0;
            dbz_q <= 1'b0;
        end else begin
            dbz_q <= dbz_req;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (start_mult) begin
                        acc   <= {{WIDTH{1'b0}}, bus.B, 1'b0};
                        mcand <= bus.A;
`ifdef MULTDIV_FAST_ZERO_EN
                        // Parking the counter at its end value sends the next edge to FINISH.
                        if (bus.A == '0 || bus.B == '0) begin
                            acc <= '0;
                            cnt <= CW'(WIDTH);
                        end
`endif
                    end
                    if (start_div) begin
                        rem   <= '0;
                        quo   <= a_mag;
                        dvsr  <= b_mag;
                        neg_q <= bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
                        neg_r <= bus.A[WIDTH-1];
                    end
                end
                MULT: begin
                    if (!last_step) begin
                        acc <= booth_next;
                        cnt <= cnt + 1'b1;
                    end else begin
                        hi_q <= acc[2*WIDTH:WIDTH+1];
                        lo_q <= acc[WIDTH:1];
                    end
                end
                DIV: begin
                    if (!last_step) begin
                        rem <= rem_next;
                        quo <= {quo[WIDTH-2:0], q_bit};
                        cnt <= cnt + 1'b1;
                    end else begin
                        hi_q <= neg_r ? -rem : rem;
                        lo_q <= neg_q ? -quo : quo;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

    assign bus.Hi        = hi_q;
    assign bus.Lo        = lo_q;
    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == FINISH);
    assign bus.divByZero = dbz_q;
    assign bus.dbg_state = state;

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Sequential signed multiply/divide unit for the multicycle MIPS datapath. It sits directly downstream of the control unit and is started by that unit's `multOP`/`divOP` pulses. It operates on the A/B register values and produces 64-bit Hi/Lo results for the HI/LO registers. It also generates the `divByZero` exception request consumed by the control unit.

## Interface
Parameters:
- `WIDTH`, default 32: operand width. The iteration count equals `WIDTH`.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset. Asserted at 0; clears all state immediately.
- `multOP`  in  1  start signed multiply; sampled on a rising edge while idle.
- `divOP`  in  1  start signed divide; sampled on a rising edge while idle.
- `A`  in  WIDTH  operand A (multiplicand / dividend), two's complement.
- `B`  in  WIDTH  operand B (multiplier / divisor), two's complement.
- `Hi`  out  WIDTH  mult: upper product half. div: remainder.
- `Lo`  out  WIDTH  mult: lower product half. div: quotient.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse; Hi/Lo are valid from this cycle onward.
- `divByZero`  out  1  one-cycle pulse on a divide start with B == 0.

## Operation
- States: IDLE, MULT, DIV, FINISH.
- IDLE:
  - `multOP`=1 → MULT. If `multOP` and `divOP` are both 1, mult wins.
  - `divOP`=1 with B≠0 → DIV.
  - `divOP`=1 with B==0 → stay in IDLE and pulse `divByZero`. No computation; Hi/Lo unchanged.
  - A and B are captured at the start edge. Later changes on A/B have no effect.
- MULT: radix-2 Booth on a 2·WIDTH+1 accumulator, arithmetic right shift. One step per cycle, WIDTH steps.
- DIV: restoring division on operand magnitudes, one quotient bit per cycle, WIDTH steps.
  - Quotient is negated if the operand signs differ; it truncates toward zero.
  - Remainder takes the sign of the dividend.
  - -2^(WIDTH-1) / -1 yields Lo=0x80000000 and Hi=0 (no exception).
- FINISH: load Hi/Lo, pulse `done`, return to IDLE.
- Start requests while `busy`=1 are ignored. No queuing.
- Hi/Lo hold their last result until the next FINISH.
- Reset (`reset`=0), including mid-operation: state=IDLE, counter=0. Hi, Lo, `busy`, `done`, `divByZero` all 0. Any in-flight operation is discarded.

## Timing
- Edge E0 samples a start; operands are captured and `busy`=1 after E0.
- Edges E1..E(WIDTH) perform the iterations.
- After edge E(WIDTH+1), FINISH is active: `done`=1, Hi/Lo are valid, and `busy` is still 1.
- After edge E(WIDTH+2): `done`=0, `busy`=0, and a new start can be sampled.
- For WIDTH=32, `done` is visible from E33 to E34. Total occupancy is 34 cycles.
- `divByZero` is high for exactly the cycle following E0. `busy` stays 0 throughout.
- `done` and `divByZero` are never asserted simultaneously.
- All outputs are registered. No combinational path from inputs to outputs.

## Configuration
- `MULTDIV_FAST_ZERO_EN`:
  - Defined: a multiply with A==0 or B==0 at E0 goes directly to FINISH. `done` is high from E1 to E2 with Hi=Lo=0; divide is unaffected.
  - Undefined: every multiply takes the full WIDTH+2 cycles.

## Test plan
- Multiply: A=7, B=0xFFFFFFFD (-3), `multOP` pulse → `done` after E33; Hi=0xFFFFFFFF, Lo=0xFFFFFFEB.
- Divide: A=0xFFFFFFF9 (-7), B=2, `divOP` pulse → Lo=0xFFFFFFFD (-3), Hi=0xFFFFFFFF (-1); `busy` is low after E34.
- Divide by zero: A=5, B=0, `divOP` → `divByZero`=1 for one cycle, `busy` stays 0, Hi/Lo keep their previous values, `done` is never raised.
- Overflow divide: A=0x80000000, B=0xFFFFFFFF → Lo=0x80000000, Hi=0, `divByZero`=0.
- Start during an operation, then reset: start a mult, pulse `divOP` at E10 → ignored, mult result unaffected. Start a new mult, drive `reset`=0 at E15 → all outputs 0 immediately and no `done` follows. After release, 3×4 gives Hi=0, Lo=12.
- With `MULTDIV_FAST_ZERO_EN` defined: A=0, B=9, `multOP` → `done` from E1 to E2, Hi=Lo=0.
- With `MULTDIV_FAST_ZERO_EN` undefined: the same stimulus gives `done` after E33.
